nvdla_glb_intr_ctrl: RTL and testbench

//  Global interrupt controller for the NVDLA core. Latches the six per-unit 2-bit done pulses

---
 rtl/nvdla_glb_pkg.sv | 48 ++++
 rtl/nvdla_glb_intr_ctrl_if.sv | 28 ++
 rtl/nvdla_glb_intr_bank.sv | 36 +++
 rtl/nvdla_glb_intr_ctrl.sv | 122 ++++++++++++
 tb/tb_nvdla_glb_intr_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nvdla_glb_pkg.sv
// NVDLA glb shared defs: register offsets, status bit map,
// CSB req/resp field layout and the mask reset value.
package nvdla_glb_pkg;

  localparam int INTR_W = 12;

  localparam logic [INTR_W-1:0] MASK_RST = 12'hFFF;

  typedef enum logic [1:0] {
    OFF_HW_VERSION  = 2'd0,
    OFF_INTR_MASK   = 2'd1,
    OFF_INTR_SET    = 2'd2,
    OFF_INTR_STATUS = 2'd3
  } reg_off_e;

  localparam int SDP_LSB      = 0;
  localparam int CDP_LSB      = 2;
  localparam int PDP_LSB      = 4;
  localparam int CDMA_DAT_LSB = 6;
  localparam int CDMA_WT_LSB  = 8;
  localparam int CACC_LSB     = 10;

  localparam int REQ_W      = 63;
  localparam int REQ_USED_W = 56;
  localparam int RESP_W     = 34;

  // low 56 bits of the request pd; [62:56] carry nothing we use
  typedef struct packed {
    logic        nposted;
    logic        write;
    logic [31:0] wdat;
    logic [21:0] addr;
  } csb_req_t;

  typedef struct packed {
    logic        is_wr;
    logic        err;
    logic [31:0] rdata;
  } csb_resp_t;

  typedef struct packed {
    logic              mask_we;
    logic              set_we;
    logic              clr_we;
    logic [INTR_W-1:0] wdat;
  } intr_wr_t;

endpackage

// File: rtl/nvdla_glb_intr_ctrl_if.sv
// CSB request/response bundle between host and glb slave.
// master drives requests; slave returns prdy and responses.
interface nvdla_glb_intr_ctrl_if;
  import nvdla_glb_pkg::*;

  logic              csb2glb_req_pvld;
  logic              csb2glb_req_prdy;
  logic [REQ_W-1:0]  csb2glb_req_pd;
  logic              glb2csb_resp_valid;
  logic [RESP_W-1:0] glb2csb_resp_pd;

  modport master (
    output csb2glb_req_pvld,
    output csb2glb_req_pd,
    input  csb2glb_req_prdy,
    input  glb2csb_resp_valid,
    input  glb2csb_resp_pd
  );

  modport slave (
    input  csb2glb_req_pvld,
    input  csb2glb_req_pd,
    output csb2glb_req_prdy,
    output glb2csb_resp_valid,
    output glb2csb_resp_pd
  );

endinterface

// File: rtl/nvdla_glb_intr_bank.sv
// Sticky status + mask flops and registered core_intr.
// Ports: hw_pulse in, wr (mask/set/w1c) in, status/mask/core_intr out.
module nvdla_glb_intr_bank
  import nvdla_glb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INTR_W-1:0] hw_pulse,
  input  intr_wr_t          wr,
  output logic [INTR_W-1:0] status,
  output logic [INTR_W-1:0] mask,
  output logic              core_intr
);

  logic [INTR_W-1:0] set_v;
  logic [INTR_W-1:0] clr_v;

  assign set_v = hw_pulse
               | (wr.set_we ? wr.wdat : '0);
  assign clr_v = wr.clr_we ? wr.wdat : '0;

  // set is OR'd after the clear so a same-cycle
  // event on a cleared bit keeps it at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status    <= '0;
      mask      <= MASK_RST;
      core_intr <= 1'b0;
    end else begin
      status    <= (status & ~clr_v) | set_v;
      if (wr.mask_we) mask <= wr.wdat;
      core_intr <= |(status & ~mask);
    end
  end

endmodule

// File: rtl/nvdla_glb_intr_ctrl.sv
// NVDLA global interrupt controller: CSB slave + intr bank.
// Ports: core clk/rstn, csb slave bundle, six done pds, core_intr.
module nvdla_glb_intr_ctrl
  import nvdla_glb_pkg::*;
#(
  parameter logic [21:0] GLB_BASE   = 22'h0,
  parameter logic [31:0] HW_VERSION = 32'h0000_0001
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  nvdla_glb_intr_ctrl_if.slave  csb,
  input  logic [1:0]            sdp2glb_done_intr_pd,
  input  logic [1:0]            cdp2glb_done_intr_pd,
  input  logic [1:0]            pdp2glb_done_intr_pd,
  input  logic [1:0]            cdma_dat2glb_done_intr_pd,
  input  logic [1:0]            cdma_wt2glb_done_intr_pd,
  input  logic [1:0]            cacc2glb_done_intr_pd,
  output logic                  core_intr
);

  csb_req_t          req;
  logic [21:0]       off;
  logic              hit;
  reg_off_e          sel;
  logic              accept;
  logic              wr_hit;
  logic              is_ver;
  logic              is_msk;
  logic              is_set;
  logic              is_sts;
  logic [31:0]       rdata;
  logic [INTR_W-1:0] hw_pulse;
  logic [INTR_W-1:0] status;
  logic [INTR_W-1:0] mask;
  intr_wr_t          wr;
  logic              resp_vld_d;
  csb_resp_t         resp_d;
  logic              prdy_q;
  logic              resp_vld_q;
  csb_resp_t         resp_q;
  logic              unused_bits;

  assign req = csb_req_t'(
    csb.csb2glb_req_pd[REQ_USED_W-1:0]);
  assign unused_bits = ^{
    csb.csb2glb_req_pd[REQ_W-1:REQ_USED_W],
    req.wdat[31:INTR_W]};

  // addresses below base wrap to huge offsets
  assign off    = req.addr - GLB_BASE;
  assign hit    = (off < 22'd4);
  assign sel    = reg_off_e'(off[1:0]);
  assign accept = csb.csb2glb_req_pvld & prdy_q;

  assign is_ver = hit & (sel == OFF_HW_VERSION);
  assign is_msk = hit & (sel == OFF_INTR_MASK);
  assign is_set = hit & (sel == OFF_INTR_SET);
  assign is_sts = hit & (sel == OFF_INTR_STATUS);

  assign wr_hit     = accept & req.write;
  assign wr.mask_we = wr_hit & is_msk;
  assign wr.set_we  = wr_hit & is_set;
  assign wr.clr_we  = wr_hit & is_sts;
  assign wr.wdat    = req.wdat[INTR_W-1:0];

  always_comb begin
    hw_pulse = '0;
    hw_pulse[SDP_LSB +: 2] = sdp2glb_done_intr_pd;
    hw_pulse[CDP_LSB +: 2] = cdp2glb_done_intr_pd;
    hw_pulse[PDP_LSB +: 2] = pdp2glb_done_intr_pd;
    hw_pulse[CDMA_DAT_LSB +: 2] =
      cdma_dat2glb_done_intr_pd;
    hw_pulse[CDMA_WT_LSB +: 2] =
      cdma_wt2glb_done_intr_pd;
    hw_pulse[CACC_LSB +: 2] = cacc2glb_done_intr_pd;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_ver:  rdata = HW_VERSION;
      is_msk:  rdata = {20'b0, mask};
      is_sts:  rdata = {20'b0, status};
      default: rdata = '0;
    endcase
  end

  // posted writes are silent; everything else answers
  assign resp_vld_d   = accept
                      & (~req.write | req.nposted);
  assign resp_d.is_wr = req.write;
  assign resp_d.err   = ~hit;
  assign resp_d.rdata = req.write ? '0 : rdata;

  always_ff @(posedge nvdla_core_clk
              or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      prdy_q     <= 1'b0;
      resp_vld_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      prdy_q     <= 1'b1;
      resp_vld_q <= resp_vld_d;
      resp_q     <= resp_vld_d ? resp_d : '0;
    end
  end

  assign csb.csb2glb_req_prdy   = prdy_q;
  assign csb.glb2csb_resp_valid = resp_vld_q;
  assign csb.glb2csb_resp_pd    = resp_q;

  nvdla_glb_intr_bank u_bank (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .hw_pulse  (hw_pulse),
    .wr        (wr),
    .status    (status),
    .mask      (mask),
    .core_intr (core_intr)
  );

endmodule

// File: tb/tb_nvdla_glb_intr_ctrl.sv
// Bench for nvdla_glb_intr_ctrl: directed vector table,
// reset corners, then random traffic against a register model.
module tb_nvdla_glb_intr_ctrl;

  logic        clk;
  logic        rstn;
  logic [1:0]  sdp, cdp, pdp, cdat, cwt, cacc;
  logic        core_intr;
  int          total;
  int          bad;

  nvdla_glb_intr_ctrl_if csb_bus ();

  nvdla_glb_intr_ctrl dut (
    .nvdla_core_clk            (clk),
    .nvdla_core_rstn           (rstn),
    .csb                       (csb_bus.slave),
    .sdp2glb_done_intr_pd      (sdp),
    .cdp2glb_done_intr_pd      (cdp),
    .pdp2glb_done_intr_pd      (pdp),
    .cdma_dat2glb_done_intr_pd (cdat),
    .cdma_wt2glb_done_intr_pd  (cwt),
    .cacc2glb_done_intr_pd     (cacc),
    .core_intr                 (core_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pvld;
    logic [62:0] pd;
    logic [11:0] pulse;
    logic        ev;
    logic [33:0] epd;
    logic        ei;
  } vec_t;

  vec_t tbl[21];

  // register model state
  logic [11:0] m_status;
  logic [11:0] m_mask;

  function automatic logic [62:0] mkpd(
    input logic w, input logic np,
    input logic [31:0] d, input logic [21:0] a);
    return {7'h0, np, w, d, a};
  endfunction

  function automatic logic [33:0] rsp(
    input logic w, input logic e, input logic [31:0] d);
    return {w, e, d};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [62:0] pd,
                       input logic [11:0] p);
    csb_bus.csb2glb_req_pvld = v;
    csb_bus.csb2glb_req_pd   = pd;
    {cacc, cwt, cdat, pdp, cdp, sdp} = p;
  endtask

  // one cycle of traffic checked against the model
  task automatic mstep(input logic v,
                       input logic [62:0] pd,
                       input logic [11:0] p,
                       input string nm);
    logic [21:0] a;
    logic [31:0] d;
    logic        w, np, mapped;
    logic        ev, ei;
    logic [31:0] erd;
    logic [11:0] setv, clrv;
    a  = pd[21:0];
    d  = pd[53:22];
    w  = pd[54];
    np = pd[55];
    mapped = (a < 22'd4);
    erd = 32'h0;
    if (v && !w) begin
      if (a == 22'd0) erd = 32'h1;
      else if (a == 22'd1) erd = {20'h0, m_mask};
      else if (a == 22'd3) erd = {20'h0, m_status};
    end
    ev = v && (!w || np);
    ei = (m_status & ~m_mask) != 12'h0;
    setv = p;
    clrv = 12'h0;
    if (v && w && a == 22'd2) setv = setv | d[11:0];
    if (v && w && a == 22'd3) clrv = d[11:0];
    drive(v, pd, p);
    @(posedge clk);
    #1;
    chk({nm, "_vld"}, 64'(csb_bus.glb2csb_resp_valid),
        64'(ev));
    if (ev)
      chk({nm, "_pd"}, 64'(csb_bus.glb2csb_resp_pd),
          64'(rsp(w, !mapped, erd)));
    chk({nm, "_intr"}, 64'(core_intr), 64'(ei));
    chk({nm, "_prdy"}, 64'(csb_bus.csb2glb_req_prdy),
        64'(1'b1));
    for (int i = 0; i < 12; i++) begin
      if (setv[i]) m_status[i] = 1'b1;
      else if (clrv[i]) m_status[i] = 1'b0;
    end
    if (v && w && a == 22'd1) m_mask = d[11:0];
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    drive(1'b0, '0, '0);

    tbl[0]  = '{1'b1, mkpd(0, 0, 0, 0), 12'h0,
                1'b1, rsp(0, 0, 32'h1), 1'b0};
    tbl[1]  = '{1'b0, '0, 12'h001,
                1'b0, '0, 1'b0};
    tbl[2]  = '{1'b1, mkpd(0, 0, 0, 3), 12'h0,
                1'b1, rsp(0, 0, 32'h001), 1'b0};
    tbl[3]  = '{1'b1, mkpd(1, 1, 32'hFFE, 1), 12'h0,
                1'b1, rsp(1, 0, 0), 1'b0};
    tbl[4]  = '{1'b0, '0, 12'h0,
                1'b0, '0, 1'b1};
    tbl[5]  = '{1'b1, mkpd(1, 1, 32'h001, 3), 12'h800,
                1'b1, rsp(1, 0, 0), 1'b1};
    tbl[6]  = '{1'b1, mkpd(0, 0, 0, 3), 12'h0,
                1'b1, rsp(0, 0, 32'h800), 1'b0};
    tbl[7]  = '{1'b1, mkpd(1, 1, 32'h801, 3), 12'h001,
                1'b1, rsp(1, 0, 0), 1'b0};
    tbl[8]  = '{1'b1, mkpd(0, 0, 0, 3), 12'h0,
                1'b1, rsp(0, 0, 32'h001), 1'b1};
    tbl[9]  = '{1'b1, mkpd(1, 0, 32'h0C0, 2), 12'h0,
                1'b0, '0, 1'b1};
    tbl[10] = '{1'b1, mkpd(0, 0, 0, 3), 12'h0,
                1'b1, rsp(0, 0, 32'h0C1), 1'b1};
    tbl[11] = '{1'b1, mkpd(0, 0, 0, 7), 12'h0,
                1'b1, rsp(0, 1, 0), 1'b1};
    tbl[12] = '{1'b1, mkpd(1, 0, 32'hFFFF_FFFF, 7), 12'h0,
                1'b0, '0, 1'b1};
    tbl[13] = '{1'b1, mkpd(0, 0, 0, 1), 12'h0,
                1'b1, rsp(0, 0, 32'hFFE), 1'b1};
    tbl[14] = '{1'b1, mkpd(0, 0, 0, 3), 12'h0,
                1'b1, rsp(0, 0, 32'h0C1), 1'b1};
    tbl[15] = '{1'b1, mkpd(0, 0, 0, 2), 12'h0,
                1'b1, rsp(0, 0, 0), 1'b1};
    tbl[16] = '{1'b1, mkpd(1, 1, 32'h5, 0), 12'h0,
                1'b1, rsp(1, 0, 0), 1'b1};
    tbl[17] = '{1'b1, mkpd(0, 0, 0, 0), 12'h0,
                1'b1, rsp(0, 0, 32'h1), 1'b1};
    tbl[18] = '{1'b1, mkpd(0, 0, 0, 4), 12'h0,
                1'b1, rsp(0, 1, 0), 1'b1};
    tbl[19] = '{1'b1, mkpd(1, 1, 32'h3, 5), 12'h0,
                1'b1, rsp(1, 1, 0), 1'b1};
    tbl[20] = '{1'b1, mkpd(0, 0, 0, 22'h3FFFFF), 12'h0,
                1'b1, rsp(0, 1, 0), 1'b1};

    // reset values, then prdy rises one edge after release
    @(posedge clk);
    #1;
    chk("rst_prdy", 64'(csb_bus.csb2glb_req_prdy), 0);
    chk("rst_vld", 64'(csb_bus.glb2csb_resp_valid), 0);
    chk("rst_pd", 64'(csb_bus.glb2csb_resp_pd), 0);
    chk("rst_intr", 64'(core_intr), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk("rel_prdy0", 64'(csb_bus.csb2glb_req_prdy), 0);
    @(posedge clk);
    #1;
    chk("rel_prdy1", 64'(csb_bus.csb2glb_req_prdy), 1);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].pvld, tbl[i].pd, tbl[i].pulse);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_vld", i),
          64'(csb_bus.glb2csb_resp_valid), 64'(tbl[i].ev));
      if (tbl[i].ev)
        chk($sformatf("vec%0d_pd", i),
            64'(csb_bus.glb2csb_resp_pd), 64'(tbl[i].epd));
      chk($sformatf("vec%0d_intr", i),
          64'(core_intr), 64'(tbl[i].ei));
    end

    // reset lands before the edge that would answer a read
    drive(1'b1, mkpd(0, 0, 0, 3), 12'h0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mrst_vld", 64'(csb_bus.glb2csb_resp_valid), 0);
    chk("mrst_intr", 64'(core_intr), 0);
    chk("mrst_prdy", 64'(csb_bus.csb2glb_req_prdy), 0);
    drive(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_vld2", 64'(csb_bus.glb2csb_resp_valid), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_prdy1", 64'(csb_bus.csb2glb_req_prdy), 1);
    chk("mrst_vld3", 64'(csb_bus.glb2csb_resp_valid), 0);

    m_status = 12'h0;
    m_mask   = 12'hFFF;
    mstep(1'b1, mkpd(0, 0, 0, 1), 12'h0, "post_mask");
    chk("post_mask_val",
        64'(csb_bus.glb2csb_resp_pd[11:0]), 64'(12'hFFF));
    mstep(1'b1, mkpd(0, 0, 0, 3), 12'h0, "post_sts");
    chk("post_sts_val",
        64'(csb_bus.glb2csb_resp_pd[11:0]), 0);

    for (int n = 0; n < 400; n++) begin
      logic        v, w, np;
      logic [21:0] a;
      logic [31:0] d;
      logic [11:0] p;
      v  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      np = $urandom_range(0, 1) == 1;
      a  = 22'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) a = 22'h3FFFF0;
      d  = $urandom;
      // keep the mask mostly open so core_intr toggles
      if (w && a == 22'd1) d = d & 32'h0000_0F0F;
      p  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : '0;
      mstep(v, mkpd(w, np, d, a), p,
            $sformatf("rnd%0d", n));
    end

    drive(1'b0, '0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
